card_dealer: RTL and testbench

//  Produces the 4-bit card codes consumed by the per-card 7-segment decoders in the baccarat datapath.
//  - Runs a free-running rank counter (1..13).
//  - On a deal request, captures the counter into one of six hand slots: player 1-3, dealer 1-3.
//  - Code 0 means "no card", which the display decoder shows as blank; codes 1..13 are A,2..10,J,Q,K.
//  - The game FSM drives deal_req/slot/clear_hand and reads the slot outputs.

---
 rtl/card_dealer_if.sv | 32 +++
 rtl/card_dealer.sv | 101 ++++++++++
 tb/tb_card_dealer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Deal-control / card-code bundle between the baccarat game FSM (master)
// and the card dealer (slave).
interface card_dealer_if #(
  parameter int unsigned CARD_W = 4
);
  logic              deal_req;
  logic [2:0]        slot;
  logic              clear_hand;
  logic [CARD_W-1:0] new_card;
  logic [CARD_W-1:0] pcard1;
  logic [CARD_W-1:0] pcard2;
  logic [CARD_W-1:0] pcard3;
  logic [CARD_W-1:0] dcard1;
  logic [CARD_W-1:0] dcard2;
  logic [CARD_W-1:0] dcard3;
  logic [2:0]        dealt_cnt;
  logic              busy;
  logic              deal_done;
  logic              deal_err;

  modport master (
    output deal_req, slot, clear_hand,
    input  new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           dealt_cnt, busy, deal_done, deal_err
  );

  modport slave (
    input  deal_req, slot, clear_hand,
    output new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           dealt_cnt, busy, deal_done, deal_err
  );
endinterface

// File: rtl/card_dealer.sv
// Free-running rank counter captured into six hand slots (player 1-3, dealer 1-3)
// on request; a two-state FSM validates the target slot and writes it.
module card_dealer #(
  parameter int unsigned NUM_RANKS = 13,
  parameter int unsigned CARD_W    = 4
) (
  input  logic          clk,
  input  logic          resetb,
  card_dealer_if.slave  bus
);
  typedef enum logic {IDLE, LOAD} state_e;

  state_e            state_q;
  logic [CARD_W-1:0] new_card_q;
  logic [CARD_W-1:0] rank_d;
  logic [CARD_W-1:0] card_q;
  logic [2:0]        slot_q;
  logic [CARD_W-1:0] slots_q [6];
  logic [2:0]        dealt_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              target_full;
  logic              slot_bad;

  always_comb begin
    rank_d = (new_card_q == CARD_W'(NUM_RANKS)) ? CARD_W'(1) : new_card_q + CARD_W'(1);
  end

  // Occupancy lookup by comparison so invalid slot codes 6/7 never index the array.
  always_comb begin
    target_full = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (slot_q == 3'(i) && slots_q[i] != '0) target_full = 1'b1;
    end
    slot_bad = (slot_q > 3'd5);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      new_card_q  <= CARD_W'(1);
      card_q      <= '0;
      slot_q      <= '0;
      dealt_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) slots_q[i] <= '0;
    end else begin
      new_card_q <= rank_d;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear_hand) begin
            for (int unsigned i = 0; i < 6; i++) slots_q[i] <= '0;
            dealt_cnt_q <= '0;
          end else if (bus.deal_req) begin
            slot_q  <= bus.slot;
            card_q  <= new_card_q;
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (bus.clear_hand) begin
            for (int unsigned i = 0; i < 6; i++) slots_q[i] <= '0;
            dealt_cnt_q <= '0;
          end else if (slot_bad || target_full) begin
            err_q <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < 6; i++) begin
              if (slot_q == 3'(i)) slots_q[i] <= card_q;
            end
            if (dealt_cnt_q != 3'd6) dealt_cnt_q <= dealt_cnt_q + 3'd1;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.new_card  = new_card_q;
  assign bus.pcard1    = slots_q[0];
  assign bus.pcard2    = slots_q[1];
  assign bus.pcard3    = slots_q[2];
  assign bus.dcard1    = slots_q[3];
  assign bus.dcard2    = slots_q[4];
  assign bus.dcard3    = slots_q[5];
  assign bus.dealt_cnt = dealt_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.deal_done = done_q;
  assign bus.deal_err  = err_q;
endmodule

// File: tb/tb_card_dealer.sv
// Directed plus randomized bench for card_dealer against a hand/counter reference model.
module tb_card_dealer;
  logic clk;
  logic resetb;

  card_dealer_if #(.CARD_W(4)) bus ();

  card_dealer #(.NUM_RANKS(13), .CARD_W(4)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counter value is a pure function of edges since reset.
  int unsigned edges;
  always @(posedge clk or negedge resetb) begin
    if (!resetb) edges <= 0;
    else         edges <= edges + 1;
  end

  int unsigned exp_hand [6];
  int unsigned exp_cnt;
  int unsigned n_pass;
  int unsigned n_total;

  function automatic int unsigned exp_rank();
    return (edges % 13) + 1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 6; i++) exp_hand[i] = 0;
    exp_cnt = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic chk_state(input string tag, input logic busy_e, input logic done_e, input logic err_e);
    chk({tag, "_new_card"}, 32'(bus.new_card), exp_rank());
    chk({tag, "_pcard1"}, 32'(bus.pcard1), exp_hand[0]);
    chk({tag, "_pcard2"}, 32'(bus.pcard2), exp_hand[1]);
    chk({tag, "_pcard3"}, 32'(bus.pcard3), exp_hand[2]);
    chk({tag, "_dcard1"}, 32'(bus.dcard1), exp_hand[3]);
    chk({tag, "_dcard2"}, 32'(bus.dcard2), exp_hand[4]);
    chk({tag, "_dcard3"}, 32'(bus.dcard3), exp_hand[5]);
    chk({tag, "_dealt_cnt"}, 32'(bus.dealt_cnt), exp_cnt);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
    chk({tag, "_done"}, 32'(bus.deal_done), 32'(done_e));
    chk({tag, "_err"}, 32'(bus.deal_err), 32'(err_e));
  endtask

  // Called at a negedge with the DUT idle; returns #1 after the done/err edge.
  task automatic do_deal(input string tag, input logic [2:0] s, input logic clr_in_load,
                         output int unsigned cap);
    logic expect_err;
    bus.deal_req = 1'b1;
    bus.slot     = s;
    cap          = exp_rank();
    @(posedge clk); #1;
    bus.deal_req = 1'b0;
    chk({tag, "_busy_hi"}, 32'(bus.busy), 1);
    if (clr_in_load) bus.clear_hand = 1'b1;
    @(posedge clk); #1;
    bus.clear_hand = 1'b0;
    if (clr_in_load) begin
      model_clear();
      chk_state(tag, 1'b0, 1'b0, 1'b0);
    end else begin
      expect_err = (s > 5) || (exp_hand[s] != 0);
      if (!expect_err) begin
        exp_hand[s] = cap;
        exp_cnt++;
      end
      chk_state(tag, 1'b0, !expect_err, expect_err);
    end
  endtask

  task automatic do_clear(input string tag, input logic with_req);
    bus.clear_hand = 1'b1;
    bus.deal_req   = with_req;
    bus.slot       = 3'd1;
    @(posedge clk); #1;
    bus.clear_hand = 1'b0;
    bus.deal_req   = 1'b0;
    model_clear();
    chk_state({tag, "_e1"}, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state({tag, "_e2"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned cap;
    int unsigned last_cap;
    n_pass  = 0;
    n_total = 0;
    model_clear();
    bus.deal_req   = 1'b0;
    bus.slot       = 3'd0;
    bus.clear_hand = 1'b0;
    resetb         = 1'b0;

    // 1: reset release and counter wrap
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    #1;
    chk_state("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_new_card_one", 32'(bus.new_card), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("wrap_13", 32'(bus.new_card), 13);
    @(posedge clk); #1;
    chk("wrap_back_1", 32'(bus.new_card), 1);
    chk_state("wrap", 1'b0, 1'b0, 1'b0);

    // async reset between edges
    @(negedge clk);
    do_deal("pre_async", 3'd4, 1'b0, cap);
    #2 resetb = 1'b0;
    #1;
    model_clear();
    chk_state("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetb = 1'b1;

    // 2: basic deal at new_card == 5
    @(negedge clk);
    for (int i = 0; i < 14 && exp_rank() != 5; i++) @(negedge clk);
    chk("align_rank5", 32'(bus.new_card), 5);
    do_deal("basic", 3'd0, 1'b0, cap);
    chk("basic_pcard1", 32'(bus.pcard1), 5);
    chk("basic_cnt", 32'(bus.dealt_cnt), 1);
    @(posedge clk); #1;
    chk("basic_done_1cyc", 32'(bus.deal_done), 0);

    // 3: occupied and invalid slots
    @(negedge clk);
    do_deal("occupied", 3'd0, 1'b0, cap);
    chk("occupied_pcard1", 32'(bus.pcard1), 5);
    @(negedge clk);
    do_deal("invalid6", 3'd6, 1'b0, cap);
    @(negedge clk);
    do_deal("invalid7", 3'd7, 1'b0, cap);

    // 4: full hand, deal_req held high across LOAD edges
    @(negedge clk);
    do_clear("pre_full", 1'b0);
    @(negedge clk);
    bus.deal_req = 1'b1;
    last_cap = 0;
    for (int s = 0; s < 6; s++) begin
      bus.slot = 3'(s);
      last_cap = exp_rank();
      @(posedge clk); #1;
      chk("full_busy", 32'(bus.busy), 1);
      @(negedge clk);
      @(posedge clk); #1;
      exp_hand[s] = last_cap;
      exp_cnt++;
      chk_state("full", 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    bus.deal_req = 1'b0;
    chk("full_cnt6", 32'(bus.dealt_cnt), 6);
    chk("full_dcard3", 32'(bus.dcard3), last_cap);
    chk("full_range", 32'((bus.pcard1 inside {[1:13]}) && (bus.pcard2 inside {[1:13]}) &&
                          (bus.pcard3 inside {[1:13]}) && (bus.dcard1 inside {[1:13]}) &&
                          (bus.dcard2 inside {[1:13]}) && (bus.dcard3 inside {[1:13]})), 1);
    do_deal("full_reject", 3'd5, 1'b0, cap);
    chk("full_cnt_sat", 32'(bus.dealt_cnt), 6);

    // 5: clear priority in IDLE and abort in LOAD
    @(negedge clk);
    do_clear("clr_idle", 1'b1);
    @(negedge clk);
    do_deal("load_fill", 3'd3, 1'b0, cap);
    @(negedge clk);
    do_deal("clr_load", 3'd2, 1'b1, cap);
    chk("clr_load_cnt0", 32'(bus.dealt_cnt), 0);

    // 6: reset while busy
    @(negedge clk);
    bus.deal_req = 1'b1;
    bus.slot     = 3'd2;
    @(posedge clk); #1;
    bus.deal_req = 1'b0;
    chk("midrst_busy_hi", 32'(bus.busy), 1);
    #2 resetb = 1'b0;
    #1;
    model_clear();
    chk_state("midrst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk); #1;
    chk_state("midrst_post", 1'b0, 1'b0, 1'b0);
    chk("midrst_pcard3", 32'(bus.pcard3), 0);

    // randomized deals and clears against the model
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) do_clear("rnd_clr", 1'($urandom_range(0, 1)));
      else do_deal("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0), cap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
